// File: rtl/triggered_event_reader.sv
// Drain side of the triggered-readout FIFO: frames each event as BoD header, hits and a hit-count
// trailer on a 32-bit stream. Define TRIGGERED_READER_TIMEOUT_EN to auto-close idle events.
module triggered_event_reader #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 flush,
    input  logic [63:0]          fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [31:0]          m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 event_open,
    output logic [CNT_WIDTH-1:0] orphan_count,
    output logic [CNT_WIDTH-1:0] zero_count,
    output logic [CNT_WIDTH-1:0] event_count
);

    typedef enum logic [2:0] {IDLE, WAIT, SEND_HI, SEND_LO, TRAILER} state_t;

    state_t               state_q, state_d;
    logic [63:0]          hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 event_open_q, event_open_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] orphan_q, orphan_d;
    logic [CNT_WIDTH-1:0] zero_q, zero_d;
    logic [CNT_WIDTH-1:0] event_cnt_q, event_cnt_d;
    logic [31:0]          m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic                 rd_en, xfer, flush_act, flush_clear, timeout;
    logic                 word_zero, word_bod;
    logic [31:0]          trailer_word;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign xfer         = m_valid_q & m_ready;
    assign flush_act    = flush_pend_q | flush;
    assign word_zero    = (fifo_dout == 64'd0);
    assign word_bod     = (fifo_dout[63:60] == 4'h2);
    assign trailer_word = {16'hE000, 16'(hit_cnt_q)};

`ifdef TRIGGERED_READER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    assign timeout = (idle_cnt_q == IDLE_LIMIT) && event_open_q && fifo_empty;

    // Counts only cycles spent waiting on an empty FIFO with an event open; holds at the limit.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (rd_en || state_d == TRAILER) begin
            idle_cnt_d = '0;
        end else if (state_q == IDLE && event_open_q && fifo_empty && idle_cnt_q != IDLE_LIMIT) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) idle_cnt_q <= '0;
        else       idle_cnt_q <= idle_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        event_open_d = event_open_q;
        hit_cnt_d    = hit_cnt_q;
        orphan_d     = orphan_q;
        zero_d       = zero_q;
        event_cnt_d  = event_cnt_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        rd_en        = 1'b0;
        flush_clear  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    state_d   = SEND_HI;
                    m_valid_d = 1'b1;
                    m_data_d  = hold_q[63:32];
                end else if (enable && !fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = WAIT;
                end else if (event_open_q && (flush_act || timeout)) begin
                    state_d   = TRAILER;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    m_data_d  = trailer_word;
                end else if (flush_act) begin
                    flush_clear = 1'b1;
                end
            end
            WAIT: begin
                hold_d = fifo_dout;
                if (word_zero) begin
                    zero_d  = sat_inc(zero_q);
                    state_d = IDLE;
                end else if (word_bod || event_open_q) begin
                    hold_full_d = 1'b1;
                    m_valid_d   = 1'b1;
                    // A new BoD while an event is open closes the old event before it is sent.
                    if (word_bod && event_open_q) begin
                        state_d  = TRAILER;
                        m_last_d = 1'b1;
                        m_data_d = trailer_word;
                    end else begin
                        state_d  = SEND_HI;
                        m_data_d = fifo_dout[63:32];
                    end
                end else begin
                    orphan_d = sat_inc(orphan_q);
                    state_d  = IDLE;
                end
            end
            SEND_HI: begin
                if (xfer) begin
                    state_d  = SEND_LO;
                    m_data_d = hold_q[31:0];
                end
            end
            SEND_LO: begin
                if (xfer) begin
                    hold_full_d = 1'b0;
                    m_valid_d   = 1'b0;
                    if (hold_q[63:60] == 4'h2) begin
                        event_open_d = 1'b1;
                        hit_cnt_d    = '0;
                    end else begin
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end
                    // Issue the next read as the hold register frees up to keep 3 cycles per word.
                    if (enable && !fifo_empty) begin
                        rd_en   = 1'b1;
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TRAILER: begin
                if (xfer) begin
                    event_open_d = 1'b0;
                    event_cnt_d  = event_cnt_q + 1'b1;
                    flush_clear  = 1'b1;
                    m_valid_d    = 1'b0;
                    m_last_d     = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        flush_pend_d = (flush_pend_q | flush) & ~flush_clear;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            event_open_q <= 1'b0;
            flush_pend_q <= 1'b0;
            hit_cnt_q    <= '0;
            orphan_q     <= '0;
            zero_q       <= '0;
            event_cnt_q  <= '0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            event_open_q <= event_open_d;
            flush_pend_q <= flush_pend_d;
            hit_cnt_q    <= hit_cnt_d;
            orphan_q     <= orphan_d;
            zero_q       <= zero_d;
            event_cnt_q  <= event_cnt_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
        end
    end

    assign fifo_rd_en   = rd_en & ~reset;
    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign event_open   = event_open_q;
    assign orphan_count = orphan_q;
    assign zero_count   = zero_q;
    assign event_count  = event_cnt_q;

endmodule

// File: tb/tb_triggered_event_reader.sv
// Self-checking bench for triggered_event_reader: directed scenarios plus a randomized event stream
// checked against a word-level framing model.
module tb_triggered_event_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        m_ready = 1'b0;
    logic [63:0] fifo_dout = 64'd0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] m_data;
    logic        m_valid, m_last, event_open;
    logic [15:0] orphan_count, zero_count, event_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] fifo_mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [32:0] out_q [$];
    int          rd_pulses = 0;
    int          stab_viol = 0;
    int          empty_reads = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;

    always #5 clock = ~clock;

    assign fifo_empty = (wr_ptr == rd_ptr);

    triggered_event_reader #(.CNT_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .event_open(event_open), .orphan_count(orphan_count), .zero_count(zero_count),
        .event_count(event_count)
    );

    // Standard-mode FIFO, output stream capture and AXI-S hold-stability monitor.
    always @(posedge clock) begin
        if (fifo_rd_en && !reset) begin
            rd_pulses <= rd_pulses + 1;
            if (rd_ptr != wr_ptr) begin
                fifo_dout <= fifo_mem[rd_ptr % 1024];
                rd_ptr    <= rd_ptr + 1;
            end else begin
                empty_reads <= empty_reads + 1;
            end
        end
        if (!reset && m_valid && m_ready) out_q.push_back({m_last, m_data});
        if (!reset && prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
            stab_viol <= stab_viol + 1;
        prev_stall <= !reset && m_valid && !m_ready;
        prev_data  <= m_data;
        prev_last  <= m_last;
    end

    task automatic push_word(input logic [63:0] w);
        fifo_mem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        wr_ptr = rd_ptr;
        reset = 1'b1; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0; enable = 1'b1; m_ready = 1'b1;
    endtask

    task automatic wait_out(input int target, input int budget);
        int n = 0;
        while (out_q.size() < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (out_q.size() < target) begin
            errors++;
            $display("[TB] FAIL out_count: got %0d words, expected %0d", out_q.size(), target);
        end
    endtask

    task automatic pulse_flush();
        @(negedge clock); flush = 1'b1;
        @(negedge clock); flush = 1'b0;
    endtask

    task automatic compare_stream(input string name, input int base, input logic [32:0] exp [$]);
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (base + i >= out_q.size() || out_q[base + i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL %s[%0d]: got %h expected %h", name, i,
                         (base + i < out_q.size()) ? out_q[base + i] : 33'h0, exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks += 8;
        if (m_valid !== 1'b0)       begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", m_valid); end
        if (m_last !== 1'b0)        begin errors++; $display("[TB] FAIL rst_last: got %b expected 0", m_last); end
        if (m_data !== 32'd0)       begin errors++; $display("[TB] FAIL rst_data: got %h expected 0", m_data); end
        if (event_open !== 1'b0)    begin errors++; $display("[TB] FAIL rst_open: got %b expected 0", event_open); end
        if (orphan_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_orphan: got %0d expected 0", orphan_count); end
        if (zero_count !== 16'd0)   begin errors++; $display("[TB] FAIL rst_zero: got %0d expected 0", zero_count); end
        if (event_count !== 16'd0)  begin errors++; $display("[TB] FAIL rst_events: got %0d expected 0", event_count); end
        if (fifo_rd_en !== 1'b0)    begin errors++; $display("[TB] FAIL rst_rd_en: got %b expected 0", fifo_rd_en); end
        do_reset();
    endtask

    task automatic test_spec_stream();
        int base;
        logic [32:0] exp [$];
        do_reset();
        base = out_q.size();
        @(negedge clock);
        push_word(64'h2000_0000_0000_0007);
        push_word(64'h5000_0000_0000_0001);
        push_word(64'h5000_0000_0000_0002);
        push_word(64'h2000_0000_0000_0008);
        #1;
        checks++;
        if (fifo_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL lat_rd: got %b expected 1", fifo_rd_en); end
        @(negedge clock);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_wait: got %b expected 0", m_valid); end
        @(negedge clock);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h2000_0000) begin
            errors++; $display("[TB] FAIL lat_first: got %b/%h expected 1/20000000", m_valid, m_data);
        end
        wait_out(base + 9, 100);
        exp = '{{1'b0, 32'h2000_0000}, {1'b0, 32'h0000_0007}, {1'b0, 32'h5000_0000}, {1'b0, 32'h0000_0001},
                {1'b0, 32'h5000_0000}, {1'b0, 32'h0000_0002}, {1'b1, 32'hE000_0002},
                {1'b0, 32'h2000_0000}, {1'b0, 32'h0000_0008}};
        compare_stream("spec_stream", base, exp);
        checks += 2;
        if (event_open !== 1'b1)    begin errors++; $display("[TB] FAIL spec_open: got %b expected 1", event_open); end
        if (event_count !== 16'd1)  begin errors++; $display("[TB] FAIL spec_events: got %0d expected 1", event_count); end
    endtask

    task automatic test_flush();
        int base;
        int n = 0;
        logic [32:0] exp [$];
        base = out_q.size();
        @(negedge clock);
        push_word(64'h5000_0000_0000_00AA);
        wait_out(base + 2, 50);
        repeat (3) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        n = 1;
        while (!(m_valid && m_last) && n < 2) begin @(negedge clock); n++; end
        checks++;
        if (!(m_valid === 1'b1 && m_last === 1'b1 && m_data === 32'hE000_0001)) begin
            errors++; $display("[TB] FAIL flush_trailer: got %b/%b/%h expected 1/1/e0000001", m_valid, m_last, m_data);
        end
        wait_out(base + 3, 20);
        @(negedge clock);
        exp = '{{1'b0, 32'h5000_0000}, {1'b0, 32'h0000_00AA}, {1'b1, 32'hE000_0001}};
        compare_stream("flush_stream", base, exp);
        checks += 2;
        if (event_open !== 1'b0)   begin errors++; $display("[TB] FAIL flush_open: got %b expected 0", event_open); end
        if (event_count !== 16'd2) begin errors++; $display("[TB] FAIL flush_events: got %0d expected 2", event_count); end
        // Flush with nothing open must be discarded, not held over for the next event.
        pulse_flush();
        repeat (4) @(negedge clock);
        base = out_q.size();
        push_word(64'h2000_0000_0000_0031);
        wait_out(base + 2, 50);
        repeat (6) @(negedge clock);
        checks += 2;
        if (out_q.size() !== base + 2) begin errors++; $display("[TB] FAIL stale_flush: got %0d words expected %0d", out_q.size(), base + 2); end
        if (event_open !== 1'b1)       begin errors++; $display("[TB] FAIL stale_open: got %b expected 1", event_open); end
    endtask

    task automatic test_orphan();
        int base, pulses;
        do_reset();
        base = out_q.size();
        pulses = rd_pulses;
        @(negedge clock);
        push_word(64'h5000_0000_0000_0009);
        repeat (10) @(negedge clock);
        checks += 4;
        if (out_q.size() !== base)      begin errors++; $display("[TB] FAIL orphan_out: got %0d expected %0d", out_q.size(), base); end
        if (orphan_count !== 16'd1)     begin errors++; $display("[TB] FAIL orphan_cnt: got %0d expected 1", orphan_count); end
        if (rd_pulses - pulses !== 1)   begin errors++; $display("[TB] FAIL orphan_rd: got %0d expected 1", rd_pulses - pulses); end
        if (event_open !== 1'b0)        begin errors++; $display("[TB] FAIL orphan_open: got %b expected 0", event_open); end
    endtask

    task automatic test_zero_word();
        int base;
        logic [32:0] exp [$];
        do_reset();
        base = out_q.size();
        @(negedge clock);
        push_word(64'h2000_0000_0000_0011);
        push_word(64'h6000_0000_0000_0001);
        push_word(64'h0);
        push_word(64'h7000_0000_0000_0002);
        wait_out(base + 6, 100);
        pulse_flush();
        wait_out(base + 7, 20);
        exp = '{{1'b0, 32'h2000_0000}, {1'b0, 32'h0000_0011}, {1'b0, 32'h6000_0000}, {1'b0, 32'h0000_0001},
                {1'b0, 32'h7000_0000}, {1'b0, 32'h0000_0002}, {1'b1, 32'hE000_0002}};
        compare_stream("zero_stream", base, exp);
        checks++;
        if (zero_count !== 16'd1) begin errors++; $display("[TB] FAIL zero_cnt: got %0d expected 1", zero_count); end
    endtask

    task automatic test_backpressure();
        int base;
        int n = 0;
        logic [32:0] exp [$];
        do_reset();
        base = out_q.size();
        m_ready = 1'b0;
        @(negedge clock);
        push_word(64'h2000_0000_0000_0021);
        push_word(64'h5555_0000_0000_1234);
        while (!m_valid && n < 10) begin @(negedge clock); n++; end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h2000_0000) begin
            errors++; $display("[TB] FAIL bp_hi: got %b/%h expected 1/20000000", m_valid, m_data);
        end
        m_ready = 1'b1;
        @(negedge clock);
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'h0000_0021 || fifo_rd_en !== 1'b0) begin
                errors++; $display("[TB] FAIL bp_stall: got %b/%h/%b expected 1/00000021/0", m_valid, m_data, fifo_rd_en);
            end
        end
        m_ready = 1'b1;
        wait_out(base + 4, 50);
        pulse_flush();
        wait_out(base + 5, 20);
        exp = '{{1'b0, 32'h2000_0000}, {1'b0, 32'h0000_0021}, {1'b0, 32'h5555_0000},
                {1'b0, 32'h0000_1234}, {1'b1, 32'hE000_0001}};
        compare_stream("bp_stream", base, exp);
        checks++;
        if (stab_viol !== 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d violations expected 0", stab_viol); end
    endtask

    task automatic test_reset_mid_event();
        int base;
        int n = 0;
        do_reset();
        base = out_q.size();
        @(negedge clock);
        push_word(64'h5000_0000_0000_0001);
        push_word(64'h2000_0000_0000_0041);
        wait_out(base + 2, 50);
        m_ready = 1'b0;
        @(negedge clock);
        push_word(64'h5000_0000_0000_0042);
        while (!m_valid && n < 10) begin @(negedge clock); n++; end
        checks += 3;
        if (m_valid !== 1'b1)       begin errors++; $display("[TB] FAIL mid_hi: got %b expected 1", m_valid); end
        if (event_open !== 1'b1)    begin errors++; $display("[TB] FAIL mid_open: got %b expected 1", event_open); end
        if (orphan_count !== 16'd1) begin errors++; $display("[TB] FAIL mid_orphan: got %0d expected 1", orphan_count); end
        reset = 1'b1;
        wr_ptr = rd_ptr;
        @(negedge clock);
        checks += 4;
        if (m_valid !== 1'b0)       begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", m_valid); end
        if (event_open !== 1'b0)    begin errors++; $display("[TB] FAIL mid_rst_open: got %b expected 0", event_open); end
        if (orphan_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_rst_orphan: got %0d expected 0", orphan_count); end
        if (m_last !== 1'b0)        begin errors++; $display("[TB] FAIL mid_rst_last: got %b expected 0", m_last); end
        reset = 1'b0;
        m_ready = 1'b1;
        repeat (8) @(negedge clock);
        checks++;
        if (out_q.size() !== base + 2) begin errors++; $display("[TB] FAIL mid_no_trailer: got %0d words expected %0d", out_q.size(), base + 2); end
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        base = out_q.size();
        @(negedge clock);
        push_word(64'h2000_0000_0000_0051);
        wait_out(base + 2, 50);
        repeat (20) @(negedge clock);
`ifdef TRIGGERED_READER_TIMEOUT_EN
        checks += 3;
        if (out_q.size() !== base + 3 || out_q[out_q.size() - 1] !== {1'b1, 32'hE000_0000}) begin
            errors++; $display("[TB] FAIL timeout_trailer: got %0d words expected %0d", out_q.size(), base + 3);
        end
        if (event_open !== 1'b0)   begin errors++; $display("[TB] FAIL timeout_open: got %b expected 0", event_open); end
        if (event_count !== 16'd1) begin errors++; $display("[TB] FAIL timeout_events: got %0d expected 1", event_count); end
`else
        checks += 3;
        if (out_q.size() !== base + 2) begin errors++; $display("[TB] FAIL no_timeout: got %0d words expected %0d", out_q.size(), base + 2); end
        if (event_open !== 1'b1)       begin errors++; $display("[TB] FAIL no_timeout_open: got %b expected 1", event_open); end
        if (event_count !== 16'd0)     begin errors++; $display("[TB] FAIL no_timeout_events: got %0d expected 0", event_count); end
`endif
    endtask

    task automatic test_random();
        logic [63:0] words [$];
        logic [32:0] exp [$];
        logic [63:0] w;
        int base, r, n;
        int open = 0, hits = 0, orph = 0, zer = 0, evc = 0;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      w = {4'h2, 28'($urandom), 32'($urandom)};
            else if (r < 28) w = 64'd0;
            else             w = {4'($urandom_range(3, 15)), 28'($urandom), 32'($urandom)};
            words.push_back(w);
        end
        // Framing model: one BoD opens an event, a later BoD or the final flush closes it.
        foreach (words[i]) begin
            w = words[i];
            if (w == 64'd0) begin
                zer++;
            end else if (w[63:60] == 4'h2) begin
                if (open != 0) begin exp.push_back({1'b1, 16'hE000, 16'(hits)}); evc++; end
                exp.push_back({1'b0, w[63:32]});
                exp.push_back({1'b0, w[31:0]});
                open = 1;
                hits = 0;
            end else if (open != 0) begin
                exp.push_back({1'b0, w[63:32]});
                exp.push_back({1'b0, w[31:0]});
                hits++;
            end else begin
                orph++;
            end
        end
        if (open != 0) begin exp.push_back({1'b1, 16'hE000, 16'(hits)}); evc++; end
        base = out_q.size();
        @(negedge clock);
        foreach (words[i]) push_word(words[i]);
        n = 0;
        while (rd_ptr != wr_ptr && n < 20000) begin
            @(negedge clock);
            enable  = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 9) < 7);
            n++;
        end
        enable = 1'b1;
        m_ready = 1'b1;
        pulse_flush();
        wait_out(base + exp.size(), 2000);
        repeat (5) @(negedge clock);
        compare_stream("rand_stream", base, exp);
        checks += 6;
        if (out_q.size() !== base + exp.size()) begin errors++; $display("[TB] FAIL rand_len: got %0d expected %0d", out_q.size() - base, exp.size()); end
        if (orphan_count !== 16'(orph)) begin errors++; $display("[TB] FAIL rand_orphan: got %0d expected %0d", orphan_count, orph); end
        if (zero_count !== 16'(zer))    begin errors++; $display("[TB] FAIL rand_zero: got %0d expected %0d", zero_count, zer); end
        if (event_count !== 16'(evc))   begin errors++; $display("[TB] FAIL rand_events: got %0d expected %0d", event_count, evc); end
        if (stab_viol !== 0)            begin errors++; $display("[TB] FAIL rand_stable: got %0d expected 0", stab_viol); end
        if (empty_reads !== 0)          begin errors++; $display("[TB] FAIL rand_empty_rd: got %0d expected 0", empty_reads); end
    endtask

    initial begin
        test_reset();
        test_spec_stream();
        test_flush();
        test_orphan();
        test_zero_word();
        test_backpressure();
        test_reset_mid_event();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
